// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush to bubbles and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter int                SKID        = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              rdy_q,        rdy_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic              accept, pop;

  // rdy_q is low through reset, so nothing is accepted until one edge after release.
  // With a skid entry it is purely registered; without one it also tracks out_ready.
  always_comb begin
    if (flush)
      in_ready = 1'b0;
    else if (SKID != 0)
      in_ready = rdy_q;
    else
      in_ready = rdy_q & (~main_valid_q | out_ready);
  end

  assign accept    = in_valid & in_ready;
  assign pop       = main_valid_q & out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : BUBBLE_CTRL;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    stall_cnt_d  = stall_cnt_q;

    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;

    if (flush) begin
      // Data is left in place; only valid and ctrl are scrubbed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = BUBBLE_CTRL;
      skid_ctrl_d  = BUBBLE_CTRL;
    end else if (SKID != 0) begin
      if (skid_valid_q) begin
        if (pop) begin
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
        end
      end else if (main_valid_q) begin
        if (accept && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_ctrl_d  = in_ctrl;
        end else if (pop) begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end
    end else begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end

    rdy_d = (SKID != 0) ? ~skid_valid_d : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= BUBBLE_CTRL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= BUBBLE_CTRL;
      rdy_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      rdy_q        <= rdy_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid-buffered instance (a_*) and a single-entry instance with a
// 4-bit stall counter (b_*), sharing clock and reset.
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 0, a_flush = 0, a_out_ready = 0;
  logic [15:0] a_in_data = '0;
  logic [7:0]  a_in_ctrl = '0;
  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [7:0]  a_out_ctrl;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_valid = 0, b_flush = 0, b_out_ready = 0;
  logic [15:0] b_in_data = '0;
  logic [7:0]  b_in_ctrl = '0;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [7:0]  b_out_ctrl;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1), .BUBBLE_CTRL(BUB), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0), .BUBBLE_CTRL(BUB), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .occupancy(b_occ), .stall_cnt(b_stall));

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_out_ctrl", a_out_ctrl, BUB);
    chk("rst_stall", a_stall, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rel_in_ready_0", a_in_ready, 0);
    tick();
    chk("rel_in_ready_1", a_in_ready, 1);

    // streaming 1..8, one-cycle latency
    a_out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      a_in_valid = 1; a_in_data = 16'(k); a_in_ctrl = 8'(k + 16);
      tick();
      chk("stream_valid", a_out_valid, 1);
      chk("stream_data", a_out_data, k);
      chk("stream_ctrl", a_out_ctrl, k + 16);
      chk("stream_occ", a_occ, 1);
    end
    a_in_valid = 0;
    tick();
    chk("stream_drain_valid", a_out_valid, 0);
    chk("stream_drain_ctrl", a_out_ctrl, BUB);
    chk("stream_stall", a_stall, 0);

    // back-pressure: out_ready low for cycles 2..4
    a_in_valid = 1; a_in_data = 16'd1; a_in_ctrl = 8'h01; a_out_ready = 1;
    tick();
    chk("bp_c1_data", a_out_data, 1);
    a_in_data = 16'd2; a_in_ctrl = 8'h02; a_out_ready = 0;
    tick();
    chk("bp_c2_occ", a_occ, 2);
    chk("bp_c2_in_ready", a_in_ready, 0);
    chk("bp_c2_data", a_out_data, 1);
    a_in_data = 16'd3; a_in_ctrl = 8'h03;
    tick();
    chk("bp_c3_occ", a_occ, 2);
    chk("bp_c3_data", a_out_data, 1);
    tick();
    chk("bp_c4_stall", a_stall, 3);
    a_out_ready = 1;
    tick();
    chk("bp_c5_data", a_out_data, 2);
    chk("bp_c5_occ", a_occ, 1);
    chk("bp_c5_in_ready", a_in_ready, 1);
    tick();
    chk("bp_c6_data", a_out_data, 3);
    a_in_data = 16'd4; a_in_ctrl = 8'h04;
    tick();
    chk("bp_c7_data", a_out_data, 4);
    a_in_valid = 0;
    tick();
    chk("bp_drain_valid", a_out_valid, 0);
    chk("bp_stall", a_stall, 3);

    // flush with both entries held and a new input offered
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h11; a_in_ctrl = 8'h11;
    tick();
    a_in_data = 16'h22; a_in_ctrl = 8'h22;
    tick();
    chk("fl_occ2", a_occ, 2);
    a_in_data = 16'hAA; a_in_ctrl = 8'hAA; a_flush = 1;
    #1;
    chk("fl_in_ready", a_in_ready, 0);
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl_out_valid", a_out_valid, 0);
    chk("fl_occ", a_occ, 0);
    chk("fl_out_ctrl", a_out_ctrl, BUB);
    chk("fl_stall", a_stall, 5);
    a_out_ready = 1;
    tick();
    chk("fl_no_aa", a_out_valid, 0);
    chk("fl_in_ready_back", a_in_ready, 1);

    // single-entry: back-pressure blocks, then replace without bubble
    b_in_valid = 1; b_in_data = 16'h101; b_in_ctrl = 8'h31; b_out_ready = 0;
    tick();
    chk("b_valid", b_out_valid, 1);
    chk("b_data1", b_out_data, 16'h101);
    chk("b_in_ready_0", b_in_ready, 0);
    b_in_data = 16'h102; b_in_ctrl = 8'h32;
    tick();
    chk("b_held", b_out_data, 16'h101);
    chk("b_stall1", b_stall, 1);
    b_out_ready = 1;
    #1;
    chk("b_in_ready_1", b_in_ready, 1);
    tick();
    chk("b_replaced_valid", b_out_valid, 1);
    chk("b_replaced_data", b_out_data, 16'h102);
    chk("b_replaced_ctrl", b_out_ctrl, 8'h32);

    // saturation of the 4-bit counter
    b_in_valid = 0; b_out_ready = 0;
    for (int i = 0; i < 13; i++) tick();
    chk("b_stall14", b_stall, 14);
    for (int i = 0; i < 7; i++) tick();
    chk("b_stall_sat", b_stall, 15);
    b_out_ready = 1;
    tick();
    chk("b_pop_ctrl", b_out_ctrl, BUB);
    chk("b_stall_hold", b_stall, 15);

    // asynchronous reset mid-traffic
    a_out_ready = 0; a_in_valid = 1; a_in_data = 16'h33; a_in_ctrl = 8'h33;
    tick();
    a_in_data = 16'h44; a_in_ctrl = 8'h44;
    tick();
    chk("mr_occ2", a_occ, 2);
    chk("mr_stall", a_stall, 6);
    a_in_valid = 0;
    rst = 1;
    #1;
    chk("mr_out_valid", a_out_valid, 0);
    chk("mr_occ", a_occ, 0);
    chk("mr_out_ctrl", a_out_ctrl, BUB);
    chk("mr_stall0", a_stall, 0);
    chk("mr_b_stall0", b_stall, 0);
    tick();
    rst = 0;
    #1;
    chk("mr_in_ready_0", a_in_ready, 0);
    tick();
    chk("mr_in_ready_1", a_in_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
